icache_direct: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 29 ++
 rtl/icache_direct.sv | 119 +++++++++++
 tb/tb_icache_direct.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions used by the instruction cache.
//
// Contents:
//   icachef_t      - fetch address split {tag, idx, bytoff}, 16 one-word frames
//   icache_frame_t - one cache frame {valid, tag, data}
//   icache_state_t - instruction cache controller states {IDLE, FILL}
package cpu_types_pkg;

  localparam int ICACHE_IDXW = 4;
  localparam int ICACHE_TAGW = 32 - ICACHE_IDXW - 2;

  typedef struct packed {
    logic [ICACHE_TAGW-1:0] tag;
    logic [ICACHE_IDXW-1:0] idx;
    logic [1:0]             bytoff;
  } icachef_t;

  typedef struct packed {
    logic                   valid;
    logic [ICACHE_TAGW-1:0] tag;
    logic [31:0]            data;
  } icache_frame_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache with one-word frames.
// Fetches that hit are answered in the same cycle. A miss latches the word
// address and issues a single-word read to the memory controller; the frame
// is written when memory drops iwait, and the next cycle can then hit.
//
// Ports:
//   CLK, nRST          clock (rising edge), synchronous active-low reset
//   imemREN, imemaddr  datapath fetch request and byte address
//   ihit, imemload     fetch hit and instruction word (0 when no hit)
//   iREN, iaddr        memory read request and word-aligned address
//   iwait, iload       memory busy flag and read data
//   hit_count          cycles with ihit=1 (wraps)
//   miss_count         fills started (wraps)
module icache_direct
  import cpu_types_pkg::*;
#(
  parameter int NFRAMES = 16,
  parameter int CNTW    = 32
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            imemREN,
  input  logic [31:0]     imemaddr,
  output logic            ihit,
  output logic [31:0]     imemload,
  output logic            iREN,
  output logic [31:0]     iaddr,
  input  logic            iwait,
  input  logic [31:0]     iload,
  output logic [CNTW-1:0] hit_count,
  output logic [CNTW-1:0] miss_count
);

  localparam int IDXW = $clog2(NFRAMES);
  localparam int TAGW = 30 - IDXW;
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  icache_state_t state;

  logic [NFRAMES-1:0] valid;
  logic [TAGW-1:0]    tags [NFRAMES];
  logic [31:0]        data [NFRAMES];

  // Word address of the outstanding fill.
  logic [29:0] fill_word;

  logic [IDXW-1:0] idx;
  logic [TAGW-1:0] tag;
  logic [IDXW-1:0] fill_idx;
  logic [TAGW-1:0] fill_tag;
  logic            hit;
  logic            fill_done;
  logic            unused_bytoff;

  assign idx      = imemaddr[IDXW+1:2];
  assign tag      = imemaddr[31:IDXW+2];
  assign fill_idx = fill_word[IDXW-1:0];
  assign fill_tag = fill_word[29:IDXW];

  // Byte offset never selects anything: every frame is one word.
  assign unused_bytoff = ^imemaddr[1:0];

  // Hits are only reported in IDLE; during a fill the frame array is about to
  // change and no forwarding of iload is done.
  assign hit       = (state == IDLE) && imemREN && valid[idx] && (tags[idx] == tag);
  assign fill_done = (state == FILL) && !iwait;

  assign ihit     = hit;
  assign imemload = hit ? data[idx] : 32'h0;
  assign iREN     = (state == FILL);
  assign iaddr    = (state == FILL) ? {fill_word, 2'b00} : 32'h0;

  // Control: FSM, valid bits and performance counters.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= IDLE;
      valid      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            hit_count <= hit_count + CNT_ONE;
          end else if (imemREN) begin
            miss_count <= miss_count + CNT_ONE;
            state      <= FILL;
          end
        end
        FILL: begin
          // The fill always runs to completion, even if the datapath has
          // dropped or changed its request in the meantime.
          if (!iwait) begin
            valid[fill_idx] <= 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Frame contents. A reset in the completing cycle suppresses the write so
  // an aborted fill cannot leave stale data behind a later valid bit.
  always_ff @(posedge CLK) begin
    if (nRST && fill_done) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= iload;
    end
  end

  // Fill address is captured when the miss is detected.
  always_ff @(posedge CLK) begin
    if ((state == IDLE) && imemREN && !hit) begin
      fill_word <= imemaddr[31:2];
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
module tb_icache_direct;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  icache_direct #(.NFRAMES(16), .CNTW(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload),
    .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp;
  int n_fail;

  // Memory responder state.
  int   wait_cnt;
  int   next_lat;
  logic force_ready;

  // Reference model: per-frame valid flag and cached word address.
  bit          m_valid [16];
  bit   [29:0] m_word  [16];
  bit          m_fill;
  bit   [29:0] m_faddr;
  logic [31:0] m_hc;
  logic [31:0] m_mc;

  typedef struct {
    logic        ren;
    logic [31:0] addr;
    logic        e_ihit;
    logic [31:0] e_load;
    logic        e_iren;
    logic [31:0] e_iaddr;
    logic [31:0] e_hc;
    logic [31:0] e_mc;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h2401_0005;
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic vec_t mk(input logic ren, input logic [31:0] addr,
                              input logic e_ihit, input logic [31:0] e_load,
                              input logic e_iren, input logic [31:0] e_iaddr,
                              input logic [31:0] e_hc, input logic [31:0] e_mc);
    vec_t v;
    v.ren = ren; v.addr = addr; v.e_ihit = e_ihit; v.e_load = e_load;
    v.e_iren = e_iren; v.e_iaddr = e_iaddr; v.e_hc = e_hc; v.e_mc = e_mc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory side: iwait held for next_lat cycles of a fill, then data returned.
  task automatic mem_drive();
    if (iREN === 1'b1) begin
      iwait = (wait_cnt != 0) && !force_ready;
      if (wait_cnt != 0) wait_cnt--;
      iload = memfn(iaddr);
    end else begin
      iwait    = 1'b1;
      iload    = $urandom;
      wait_cnt = next_lat;
    end
  endtask

  function automatic logic model_hit(input logic ren, input logic [31:0] addr);
    int i;
    i = int'(addr[5:2]);
    return !m_fill && ren && m_valid[i] && (m_word[i] == addr[31:2]);
  endfunction

  task automatic model_check(input logic ren, input logic [31:0] addr);
    logic h;
    h = model_hit(ren, addr);
    chk("ihit", {31'b0, ihit}, {31'b0, h});
    chk("imemload", imemload, h ? memfn({addr[31:2], 2'b00}) : 32'h0);
    chk("iREN", {31'b0, iREN}, {31'b0, m_fill});
    chk("iaddr", iaddr, m_fill ? {m_faddr, 2'b00} : 32'h0);
    chk("hit_count", hit_count, m_hc);
    chk("miss_count", miss_count, m_mc);
  endtask

  task automatic model_update(input logic rst_n, input logic ren, input logic [31:0] addr);
    int i;
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
      m_fill = 1'b0;
      m_hc   = 32'h0;
      m_mc   = 32'h0;
    end else if (m_fill) begin
      if (!iwait) begin
        i          = int'(m_faddr[3:0]);
        m_valid[i] = 1'b1;
        m_word[i]  = m_faddr;
        m_fill     = 1'b0;
      end
    end else if (ren) begin
      if (model_hit(ren, addr)) begin
        m_hc = m_hc + 32'd1;
      end else begin
        m_mc    = m_mc + 32'd1;
        m_fill  = 1'b1;
        m_faddr = addr[31:2];
      end
    end
  endtask

  // One clock cycle, entered and left at 1 time unit after a rising edge.
  task automatic cycle(input logic rst_n, input logic ren, input logic [31:0] addr,
                       input bit do_chk);
    nRST     = rst_n;
    imemREN  = ren;
    imemaddr = addr;
    mem_drive();
    @(negedge CLK);
    if (do_chk) model_check(ren, addr);
    model_update(rst_n, ren, addr);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vec_t v;
    logic [31:0] a;
    logic [31:0] hc_s;
    logic [31:0] mc_s;
    n_cmp       = 0;
    n_fail      = 0;
    next_lat    = 3;
    wait_cnt    = 3;
    force_ready = 1'b0;
    nRST        = 1'b0;
    imemREN     = 1'b0;
    imemaddr    = 32'h0;
    iwait       = 1'b1;
    iload       = 32'h0;
    m_fill      = 1'b0;
    m_faddr     = '0;
    m_hc        = 32'h0;
    m_mc        = 32'h0;
    for (int k = 0; k < 16; k++) begin
      m_valid[k] = 1'b0;
      m_word[k]  = '0;
    end

    @(posedge CLK);
    #1;
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);

    // Cold miss, repeat hits and a conflict miss, memory latency 3.
    tbl.push_back(mk(1, 32'h40, 0, 0, 0, 32'h0, 0, 0));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(1, 32'h40, 0, 0, 1, 32'h40, 0, 1));
    for (int k = 0; k < 6; k++) tbl.push_back(mk(1, 32'h40, 1, 32'h2401_0005, 0, 32'h0, k, 1));
    tbl.push_back(mk(0, 32'h40, 0, 0, 0, 32'h0, 6, 1));
    tbl.push_back(mk(1, 32'h440, 0, 0, 0, 32'h0, 6, 1));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(1, 32'h440, 0, 0, 1, 32'h440, 6, 2));
    tbl.push_back(mk(1, 32'h440, 1, memfn(32'h440), 0, 32'h0, 6, 2));
    tbl.push_back(mk(1, 32'h40, 0, 0, 0, 32'h0, 7, 2));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(1, 32'h40, 0, 0, 1, 32'h40, 7, 3));
    tbl.push_back(mk(1, 32'h40, 1, 32'h2401_0005, 0, 32'h0, 7, 3));

    for (int r = 0; r < tbl.size(); r++) begin
      v        = tbl[r];
      nRST     = 1'b1;
      imemREN  = v.ren;
      imemaddr = v.addr;
      mem_drive();
      @(negedge CLK);
      chk($sformatf("tbl%0d.ihit", r), {31'b0, ihit}, {31'b0, v.e_ihit});
      chk($sformatf("tbl%0d.imemload", r), imemload, v.e_load);
      chk($sformatf("tbl%0d.iREN", r), {31'b0, iREN}, {31'b0, v.e_iren});
      chk($sformatf("tbl%0d.iaddr", r), iaddr, v.e_iaddr);
      chk($sformatf("tbl%0d.hit_count", r), hit_count, v.e_hc);
      chk($sformatf("tbl%0d.miss_count", r), miss_count, v.e_mc);
      model_update(1'b1, v.ren, v.addr);
      @(posedge CLK);
      #1;
    end

    // Misaligned address hits the word already cached at 0x40.
    cycle(1, 1, 32'h43, 1);

    // Address changes during a fill: the latched address is still fetched.
    cycle(1, 1, 32'h80, 1);
    chk("midfill.iaddr", iaddr, 32'h80);
    for (int k = 0; k < 4; k++) cycle(1, 1, 32'h84, 1);
    chk("midfill.done_iREN", {31'b0, iREN}, 32'h0);
    cycle(1, 1, 32'h84, 1);
    chk("second.iaddr", iaddr, 32'h84);
    for (int k = 0; k < 4; k++) cycle(1, 1, 32'h84, 1);
    cycle(1, 1, 32'h84, 1);
    cycle(1, 1, 32'h80, 1);

    // Reset lands on the edge where memory completes the fill.
    cycle(1, 1, 32'h100, 1);
    force_ready = 1'b1;
    cycle(0, 1, 32'h100, 1);
    force_ready = 1'b0;
    chk("rstfill.iREN", {31'b0, iREN}, 32'h0);
    chk("rstfill.hit_count", hit_count, 32'h0);
    chk("rstfill.miss_count", miss_count, 32'h0);
    cycle(1, 1, 32'h80, 1);
    chk("rstfill.refetch_iREN", {31'b0, iREN}, 32'h1);
    for (int k = 0; k < 4; k++) cycle(1, 0, 32'h0, 1);
    cycle(1, 1, 32'h100, 1);
    for (int k = 0; k < 4; k++) cycle(1, 1, 32'h100, 1);

    // No requests: nothing moves.
    hc_s = hit_count;
    mc_s = miss_count;
    for (int k = 0; k < 10; k++) cycle(1, 0, $urandom, 1);
    chk("idle.hit_count", hit_count, hc_s);
    chk("idle.miss_count", miss_count, mc_s);

    // Randomized traffic over a small address pool to get hits and conflicts.
    for (int k = 0; k < 800; k++) begin
      next_lat = $urandom_range(0, 3);
      a = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
      cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), a, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
